// File: rtl/sig_conditioner.sv
// Board-input conditioner: synchronizer chain, debounce FSM with stability counter,
// and registered rise/fall pulses, toggle level and wrapping press counter.
module sig_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       sig,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       toggle,
  output logic [7:0] press_count
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam bit              ONE_SHOT = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  state_t                 state;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Pulses default low every cycle so they can only last the one cycle they are set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOW;
      cnt         <= '0;
      sig         <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      toggle      <= 1'b0;
      press_count <= 8'd0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        S_LOW: begin
          if (sync_out) begin
            if (ONE_SHOT) begin
              state       <= S_HIGH;
              sig         <= 1'b1;
              rise_pulse  <= 1'b1;
              toggle      <= ~toggle;
              press_count <= press_count + 8'd1;
            end else begin
              state <= S_CHK_HIGH;
              cnt   <= CW'(1);
            end
          end
        end
        S_CHK_HIGH: begin
          if (!sync_out) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= S_HIGH;
            cnt         <= '0;
            sig         <= 1'b1;
            rise_pulse  <= 1'b1;
            toggle      <= ~toggle;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (!sync_out) begin
            if (ONE_SHOT) begin
              state      <= S_LOW;
              sig        <= 1'b0;
              fall_pulse <= 1'b1;
            end else begin
              state <= S_CHK_LOW;
              cnt   <= CW'(1);
            end
          end
        end
        S_CHK_LOW: begin
          if (sync_out) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= S_LOW;
            cnt        <= '0;
            sig        <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sig_conditioner.sv
// Directed bench for sig_conditioner at default parameters (2 sync stages, 4 stable cycles).
module tb_sig_conditioner;

  logic       clk, rst_n, btn_in;
  logic       sig, rise_pulse, fall_pulse, toggle;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  sig_conditioner #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .sig(sig), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .toggle(toggle), .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [11:0] obs();
    return {sig, rise_pulse, fall_pulse, toggle, press_count};
  endfunction

  task automatic do_reset();
    btn_in = 1'b0;
    rst_n  = 1'b0;
    tick(3);
    rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] o;
    rst_n  = 1'b1;
    btn_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    o = obs();
    n_checks++;
    if (o !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected 000", o);
    end
    tick(3);
    o = obs();
    n_checks++;
    if (o !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected 000", o);
    end
    rst_n = 1'b1;
  endtask

  // btn_in rises just before edge 1 and is held; sig rises after edge 6.
  task automatic test_clean_press();
    logic [11:0] o, e;
    btn_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      o = obs();
      e = {(k >= 6), (k == 6), 1'b0, (k >= 6), ((k >= 6) ? 8'd1 : 8'd0)};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_release();
    logic [11:0] o, e;
    btn_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      o = obs();
      e = {(k < 6), 1'b0, (k == 6), 1'b1, 8'd1};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL release edge %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  // High 3, low 2, high 10: only the final rising edge (before edge 6) yields a press, at edge 11.
  task automatic test_bounce();
    logic [11:0] o, e;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      btn_in = (k <= 3) || (k >= 6);
      tick(1);
      o = obs();
      e = {(k >= 11), (k == 11), 1'b0, (k >= 11), ((k >= 11) ? 8'd1 : 8'd0)};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bounce edge %0d: got %h expected %h", k, o, e);
      end
    end
    btn_in = 1'b0;
    tick(10);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 1; p <= 256; p++) begin
      btn_in = 1'b1;
      tick(8);
      btn_in = 1'b0;
      tick(8);
      if (p == 255) begin
        n_checks++;
        if (press_count !== 8'd255 || toggle !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap_255: got count %0d toggle %b expected 255 1", press_count, toggle);
        end
      end
    end
    n_checks++;
    if (press_count !== 8'd0 || toggle !== 1'b0 || sig !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_256: got count %0d toggle %b sig %b expected 0 0 0",
               press_count, toggle, sig);
    end
  endtask

  task automatic test_reset_mid_check();
    logic [11:0] o, e;
    // One full press/release first so toggle and press_count are non-zero.
    btn_in = 1'b1;
    tick(8);
    btn_in = 1'b0;
    tick(8);
    n_checks++;
    if (obs() !== 12'h101) begin
      n_fail++;
      $display("FAIL mid_pre: got %h expected 101", obs());
    end
    btn_in = 1'b1;
    tick(4);
    #1 rst_n = 1'b0;
    #1;
    o = obs();
    n_checks++;
    if (o !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %h expected 000", o);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      o = obs();
      e = {(k >= 6), (k == 6), 1'b0, (k >= 6), ((k >= 6) ? 8'd1 : 8'd0)};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mid_release edge %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_wrap();
    test_reset_mid_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
